// File: rtl/uart_pkg.sv
// Shared constants for the UART transmitter: FSM state encoding, 8N1 frame levels
// and the default divisor width.
package uart_pkg;

  localparam int DIV_W_DEFAULT = 16;
  localparam int DATA_BITS     = 8;
  localparam logic START_LVL   = 1'b0;
  localparam logic STOP_LVL    = 1'b1;

  typedef logic [1:0] uart_state_t;
  localparam uart_state_t ST_IDLE  = 2'd0;
  localparam uart_state_t ST_START = 2'd1;
  localparam uart_state_t ST_DATA  = 2'd2;
  localparam uart_state_t ST_STOP  = 2'd3;

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit byte queue. With UART_TX_FIFO_EN defined it is a DEPTH-entry circular
// buffer; otherwise it collapses to a single holding register.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [DATA_BITS-1:0] push_data,
  input  logic                 pop,
  output logic [DATA_BITS-1:0] pop_data,
  output logic                 full,
  output logic                 empty
);

`ifdef UART_TX_FIFO_EN
  localparam int PW = $clog2(DEPTH);

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [DATA_BITS-1:0] mem_d [DEPTH];
  logic [PW-1:0]        rd_q, rd_d, wr_q, wr_d;
  logic [PW:0]          cnt_q, cnt_d;
  logic                 push_ok, pop_ok;

  assign full     = (cnt_q == (PW+1)'(DEPTH));
  assign empty    = (cnt_q == (PW+1)'(0));
  assign pop_data = mem_q[rd_q];

  // Next-state for storage, pointers (wrap by power-of-two width) and occupancy.
  always_comb begin
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    push_ok = push && !full;
    pop_ok  = pop && !empty;
    if (push_ok) begin
      mem_d[wr_q] = push_data;
      wr_d        = wr_q + PW'(1);
    end else begin
      wr_d = wr_q;
    end
    if (pop_ok) begin
      rd_d = rd_q + PW'(1);
    end else begin
      rd_d = rd_q;
    end
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Queue registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {DATA_BITS{1'b0}};
      rd_q  <= {PW{1'b0}};
      wr_q  <= {PW{1'b0}};
      cnt_q <= {(PW+1){1'b0}};
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end
`else
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 vld_q, vld_d;
  logic                 unused_depth;

  assign unused_depth = (DEPTH > 0);
  assign full         = vld_q;
  assign empty        = !vld_q;
  assign pop_data     = hold_q;

  // A push is only possible while empty, a pop only while full, so they never collide.
  always_comb begin
    hold_d = hold_q;
    vld_d  = vld_q;
    if (push && !vld_q) begin
      hold_d = push_data;
      vld_d  = 1'b1;
    end else if (pop && vld_q) begin
      vld_d = 1'b0;
    end else begin
      vld_d = vld_q;
    end
  end

  // Holding register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q <= {DATA_BITS{1'b0}};
      vld_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      vld_q  <= vld_d;
    end
  end
`endif

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a programmable bit period and a transmit queue
// (multi-entry FIFO when UART_TX_FIFO_EN is defined, single holding register otherwise).
module uart_tx
  import uart_pkg::*;
#(
  parameter int DIV_W      = DIV_W_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  input  logic [7:0]       wr_data,
  output logic             wr_ready,
  input  logic [DIV_W-1:0] divisor,
  output logic             tx,
  output logic             busy
);

  uart_state_t    state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d;
  logic [2:0]     idx_q, idx_d;
  logic [7:0]     sh_q, sh_d;
  logic           tx_q, tx_d;
  logic           q_push, q_pop, q_full, q_empty;
  logic [7:0]     q_head;

  assign wr_ready = !q_full && rst_n;
  assign q_push   = wr_valid && wr_ready;
  assign tx       = tx_q;
  assign busy     = rst_n && ((state_q != ST_IDLE) || !q_empty);

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (q_push),
    .push_data (wr_data),
    .pop       (q_pop),
    .pop_data  (q_head),
    .full      (q_full),
    .empty     (q_empty)
  );

  // Frame sequencer; tx_d is the level the line takes after the edge, so tx stays a flop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    q_pop   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!q_empty) begin
          q_pop   = 1'b1;
          sh_d    = q_head;
          div_d   = divisor;
          cnt_d   = divisor;
          state_d = ST_START;
          tx_d    = START_LVL;
        end else begin
          tx_d = STOP_LVL;
        end
      end
      ST_START: begin
        if (cnt_q == DIV_W'(0)) begin
          cnt_d   = div_q;
          idx_d   = 3'd0;
          state_d = ST_DATA;
          tx_d    = sh_q[0];
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == DIV_W'(0)) begin
          cnt_d = div_q;
          if (idx_q == 3'(DATA_BITS - 1)) begin
            state_d = ST_STOP;
            tx_d    = STOP_LVL;
          end else begin
            idx_d = idx_q + 3'd1;
            sh_d  = {1'b0, sh_q[7:1]};
            tx_d  = sh_q[1];
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      ST_STOP: begin
        // Back-to-back frames: a waiting byte starts immediately with a freshly latched divisor.
        if (cnt_q == DIV_W'(0)) begin
          if (!q_empty) begin
            q_pop   = 1'b1;
            sh_d    = q_head;
            div_d   = divisor;
            cnt_d   = divisor;
            state_d = ST_START;
            tx_d    = START_LVL;
          end else begin
            state_d = ST_IDLE;
            tx_d    = STOP_LVL;
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = STOP_LVL;
      end
    endcase
  end

  // Sequencer registers; reset abandons any frame and returns the line to idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= {DIV_W{1'b0}};
      div_q   <= {DIV_W{1'b0}};
      idx_q   <= 3'd0;
      sh_q    <= 8'd0;
      tx_q    <= STOP_LVL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx; FIFO scenarios run when UART_TX_FIFO_EN is defined,
// single-holding-register scenarios otherwise.
module tb_uart_tx;

  localparam int DIV_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wr_valid = 1'b0;
  logic [7:0]       wr_data = 8'h00;
  logic             wr_ready;
  logic [DIV_W-1:0] divisor = 16'd7;
  logic             tx;
  logic             busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx #(.DIV_W(DIV_W), .FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .divisor  (divisor),
    .tx       (tx),
    .busy     (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Expects a full frame starting on the next cycle: per cycles for each of 10 bits.
  task automatic check_frame(input logic [7:0] b, input int per, input string name);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < per; c++) begin
        step();
        checks++;
        if (tx !== bits[i]) begin
          failures++;
          $display("FAIL %s bit%0d cyc%0d tx=%b expected=%b", name, i, c, tx, bits[i]);
        end
      end
    end
  endtask

  // Presents a byte until accepted; returns in the cycle after the accepting edge.
  task automatic push_byte(input logic [7:0] b, input int max_wait, output int waits);
    waits    = 0;
    wr_valid = 1'b1;
    wr_data  = b;
    while (wr_ready !== 1'b1 && waits < max_wait) begin
      step();
      waits++;
    end
    checks++;
    if (wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL push_%h timeout wr_ready=%b expected=1", b, wr_ready);
      wr_valid = 1'b0;
    end else begin
      step();
      wr_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    wr_valid = 1'b1;
    wr_data  = 8'h00;
    step();
    step();
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || wr_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold tx=%b busy=%b wr_ready=%b expected 1/0/0", tx, busy, wr_ready);
    end
    wr_valid = 1'b0;
    rst_n    = 1'b1;
    step();
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release tx=%b busy=%b wr_ready=%b expected 1/0/1", tx, busy, wr_ready);
    end
  endtask

  task automatic test_basic_frame();
    int w;
    do_reset();
    divisor = 16'd7;
    push_byte(8'h55, 4, w);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b1 || w != 0) begin
      failures++;
      $display("FAIL basic_cyc0 tx=%b busy=%b waits=%0d expected 1/1/0", tx, busy, w);
    end
    check_frame(8'h55, 8, "basic55");
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_busy80 busy=%b expected=1", busy);
    end
    step();
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      failures++;
      $display("FAIL basic_busy81 busy=%b tx=%b expected 0/1", busy, tx);
    end
  endtask

  task automatic test_div0();
    int w;
    do_reset();
    divisor = 16'd0;
    push_byte(8'h80, 4, w);
    check_frame(8'h80, 1, "div0");
    step();
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      failures++;
      $display("FAIL div0_end busy=%b tx=%b expected 0/1", busy, tx);
    end
    divisor = 16'd7;
  endtask

  task automatic test_div_change();
    int w1, w2;
    do_reset();
    divisor = 16'd7;
    push_byte(8'hA5, 4, w1);
    fork
      push_byte(8'h3C, 200, w2);
      begin
        repeat (20) step();
        divisor = 16'd3;
      end
      begin
        check_frame(8'hA5, 8, "divchg_f1");
        check_frame(8'h3C, 4, "divchg_f2");
      end
    join
    step();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL divchg_end busy=%b expected=0", busy);
    end
    divisor = 16'd7;
  endtask

  task automatic test_reset_mid_frame();
    int w, bad;
    do_reset();
    divisor = 16'd7;
    push_byte(8'hC3, 4, w);
    fork
      begin
        push_byte(8'h5A, 200, w);
`ifdef UART_TX_FIFO_EN
        push_byte(8'h96, 200, w);
`endif
      end
      begin
        repeat (44) step();
        checks++;
        if (tx !== 1'b0) begin
          failures++;
          $display("FAIL rstmid_bit4 tx=%b expected=0", tx);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (wr_ready !== 1'b0 || busy !== 1'b0) begin
          failures++;
          $display("FAIL rstmid_low wr_ready=%b busy=%b expected 0/0", wr_ready, busy);
        end
        step();
        rst_n = 1'b1;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
          failures++;
          $display("FAIL rstmid_after tx=%b busy=%b expected 1/0", tx, busy);
        end
      end
    join
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL rstmid_quiet active_cycles=%0d expected=0", bad);
    end
  endtask

`ifndef UART_TX_FIFO_EN
  task automatic test_hold_stall();
    int w1, w2;
    do_reset();
    divisor = 16'd7;
    push_byte(8'h11, 4, w1);
    checks++;
    if (wr_ready !== 1'b0) begin
      failures++;
      $display("FAIL hold_full wr_ready=%b expected=0", wr_ready);
    end
    fork
      push_byte(8'h22, 200, w2);
      begin
        check_frame(8'h11, 8, "hold_f11");
        check_frame(8'h22, 8, "hold_f22");
      end
    join
    checks++;
    if (w2 != 1) begin
      failures++;
      $display("FAIL hold_stall waits=%0d expected=1", w2);
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL hold_end busy=%b expected=0", busy);
    end
  endtask
`else
  task automatic test_fifo_burst();
    int w, total;
    do_reset();
    divisor = 16'd7;
    total   = 0;
    push_byte(8'h01, 4, w);
    fork
      begin
        for (int i = 2; i <= 5; i++) begin
          push_byte(8'(i), 200, w);
          total += w;
        end
      end
      begin
        for (int i = 1; i <= 5; i++) check_frame(8'(i), 8, "burst");
      end
    join
    checks++;
    if (total != 0) begin
      failures++;
      $display("FAIL burst_stalls stalls=%0d expected=0", total);
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL burst_end busy=%b expected=0", busy);
    end
  endtask

  task automatic test_fifo_full();
    int w, ready_hi, bad;
    do_reset();
    divisor  = 16'd7;
    ready_hi = 0;
    push_byte(8'h10, 4, w);
    fork
      begin
        for (int i = 2; i <= 5; i++) push_byte(8'(i * 16), 200, w);
        checks++;
        if (wr_ready !== 1'b0) begin
          failures++;
          $display("FAIL full_ready wr_ready=%b expected=0", wr_ready);
        end
        wr_valid = 1'b1;
        wr_data  = 8'hAA;
        for (int i = 0; i < 20; i++) begin
          if (wr_ready !== 1'b0) ready_hi++;
          step();
        end
        wr_valid = 1'b0;
      end
      begin
        for (int i = 1; i <= 5; i++) check_frame(8'(i * 16), 8, "full");
      end
    join
    checks++;
    if (ready_hi != 0) begin
      failures++;
      $display("FAIL full_refuse ready_cycles=%0d expected=0", ready_hi);
    end
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL full_noaa active_cycles=%0d expected=0", bad);
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_frame();
    test_div0();
    test_div_change();
    test_reset_mid_frame();
`ifdef UART_TX_FIFO_EN
    test_fifo_burst();
    test_fifo_full();
`else
    test_hold_stall();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DIV_W, default 16, meaning width of the bit-period divisor.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning transmit queue entries (power of two, >=2) when UART_TX_FIFO_EN is defined.
REQ-003 SHALL have port clk, input, 1, the single system clock.
REQ-004 SHALL have port rst_n, input, 1, reset: synchronous and active-low.
REQ-005 SHALL have port wr_valid, input, 1, meaning CPU byte-write request.
REQ-006 SHALL have port wr_data, input, 8, meaning the byte to send.
REQ-007 SHALL have port wr_ready, output, 1, meaning the queue can accept a byte this cycle.
REQ-008 SHALL have port divisor, input, DIV_W, meaning bit period minus one, in clk cycles.
REQ-009 SHALL have port tx, output, 1, meaning the serial line (drives uo_out[6] at top level).
REQ-010 SHALL have port busy, output, 1, meaning the queue is non-empty or a frame is in flight.

Function
REQ-011 SHALL transmit 8N1 frames: start bit 0, data bits LSB first, one stop bit 1; idle level 1.
REQ-012 SHALL hold every bit on tx for exactly divisor+1 clk cycles; divisor=0 gives 1 cycle/bit.
REQ-013 SHALL latch divisor at frame start; changes mid-frame apply from the next frame only.
REQ-014 SHALL accept a byte on a clk edge where wr_valid && wr_ready.
REQ-015 SHALL drive wr_ready = !full && rst_n, combinationally from queue occupancy.
REQ-016 SHALL ignore wr_valid while the queue is full: no overwrite and no error flag.
REQ-017 SHALL implement states IDLE, START, DATA, STOP, held in a 2-bit state register.
REQ-018 SHALL move IDLE->START when the queue is non-empty, popping the head byte into an 8-bit shift register in the same cycle.
REQ-019 SHALL drive tx low on the cycle after the accepting edge when idle, giving a write-to-start-bit latency of 1 cycle.
REQ-020 SHALL move START->DATA->STOP on bit-counter expiry; DATA uses a 3-bit bit index and wraps 7->STOP.
REQ-021 SHALL go from STOP directly to START with no idle gap if the queue is non-empty at stop-bit end, and to IDLE otherwise.
REQ-022 SHALL treat a simultaneous push and pop as a net-zero occupancy change; a push into a full queue in the same cycle as a pop is still refused.
REQ-023 SHALL register tx so that it is glitch-free.
REQ-024 SHALL drive busy = (state != IDLE) || !empty.

Reset
REQ-025 SHALL, while rst_n is low at a clk edge, set state IDLE, tx=1, queue empty, bit counter 0, and bit index 0.
REQ-026 SHALL, on reset mid-frame, abandon the frame and queue immediately, with tx=1 after that edge and no partial frame resumed.
REQ-027 SHALL hold wr_ready=0 and busy=0 while rst_n is low.

Configuration
REQ-028 SHALL, with UART_TX_FIFO_EN defined, queue up to FIFO_DEPTH bytes in a circular buffer whose read and write pointers wrap modulo FIFO_DEPTH.
REQ-029 SHALL, without UART_TX_FIFO_EN, use a single holding register: wr_ready=0 from an accepted write until that byte is popped at frame start, so one byte can be queued behind the frame in flight.

Structure
REQ-030 SHALL place the state enum, the frame constants (DATA_BITS=8, START_LVL=0, STOP_LVL=1) and the default DIV_W in shared package uart_pkg.
REQ-031 SHALL put the queue in sub-module uart_tx_fifo, which has push/pop/full/empty ports and the depth parameter, and degenerates to one register when UART_TX_FIFO_EN is undefined.

Verification
REQ-032 SHALL check this case: divisor=7, write 0x55 at cycle 0 -> tx=0 for cycles 1-8, then 1,0,1,0,1,0,1,0 for 8 cycles each, then stop high 8 cycles; frame is 80 cycles and busy falls at cycle 81.
REQ-033 SHALL check this case: FIFO_EN, divisor=7, 5 back-to-back writes 0x01..0x05 -> the 5th is accepted once the first is popped, then 400 contiguous frame cycles with no idle gap between stop and start bits.
REQ-034 SHALL check this case: FIFO_EN, queue full with frame in flight, wr_valid=1 with 0xAA -> wr_ready=0, and 0xAA never appears on tx.
REQ-035 SHALL check this case: divisor changed from 7 to 3 during DATA of frame 1 -> frame 1 keeps 8 cycles/bit, and frame 2 uses 4 cycles/bit.
REQ-036 SHALL check this case: rst_n low for 1 cycle during bit 4 of a frame with 2 bytes queued -> tx=1 the next cycle, busy=0, and no further frames.
REQ-037 SHALL check this case: no FIFO_EN, write 0x11 then 0x22 on consecutive cycles -> 0x22 is stalled, accepted only after 0x11 pops, then sent directly after 0x11's stop bit.
